// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: FETCH/EXEC/FAULT sequencer with PC update
// and a bounded wait for the instruction-memory acknowledge.
module instr_fetch_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] startpc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        branch,
  input  logic        uncond_branch,
  input  logic        zero,
  input  logic [63:0] extimm,
  output logic [63:0] currentpc,
  output logic [31:0] instr,
  output logic [10:0] opcode,
  output logic        instr_valid,
  output logic        fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [15:0] LIMIT = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [63:0] pc;
  logic [63:0] pc_nx;
  logic [63:0] nextpc;
  logic [31:0] ir;
  logic [31:0] ir_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;
  logic        fault_q;
  logic        fault_nx;
  logic        take;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= startpc;
      cnt     <= '0;
      ir      <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      cnt     <= cnt_nx;
      ir      <= ir_nx;
      fault_q <= fault_nx;
    end
  end

  // Branch controls only matter in EXEC, so X elsewhere is harmless.
  always_comb begin
    take   = uncond_branch | (branch & zero);
    nextpc = take ? pc + (extimm << 2) : pc + 64'd4;
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    cnt_nx   = cnt;
    ir_nx    = ir;
    fault_nx = fault_q;
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          ir_nx    = imem_data;
          state_nx = EXEC;
        end else if (cnt == LIMIT) begin
          state_nx = FAULT;
          fault_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      EXEC: begin
        pc_nx    = nextpc;
        cnt_nx   = '0;
        state_nx = FETCH;
      end
      FAULT: begin
        fault_nx = 1'b1;
      end
      default: begin
        state_nx = FETCH;
        cnt_nx   = '0;
      end
    endcase
  end

  // Request and valid are masked while reset is held.
  always_comb begin
    imem_req    = (state == FETCH) && !reset;
    instr_valid = (state == EXEC) && !reset;
    instr       = instr_valid ? ir : 32'h0000_0000;
    opcode      = instr[31:21];
    imem_addr   = pc;
    currentpc   = pc;
    fault       = fault_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic [63:0] startpc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        branch;
  logic        uncond_branch;
  logic        zero;
  logic [63:0] extimm;
  logic [63:0] currentpc;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic        instr_valid;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.ACK_TIMEOUT(4)) dut (
    .CLK(CLK),
    .reset(reset),
    .startpc(startpc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .branch(branch),
    .uncond_branch(uncond_branch),
    .zero(zero),
    .extimm(extimm),
    .currentpc(currentpc),
    .instr(instr),
    .opcode(opcode),
    .instr_valid(instr_valid),
    .fault(fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] pc);
    reset = 1'b1;
    startpc = pc;
    imem_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic no_br();
    branch = 1'b0;
    uncond_branch = 1'b0;
    zero = 1'b0;
    extimm = 64'd0;
  endtask

  initial begin
    reset = 1'b1;
    startpc = 64'h1000;
    imem_ack = 1'b0;
    imem_data = 32'h0;
    no_br();
    tick();
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_pc", currentpc, 64'h1000);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);

    reset = 1'b0;
    imem_ack = 1'b1;
    imem_data = 32'hABCD_1234;
    #1;
    chk("req_after_rst", {63'd0, imem_req}, 64'd1);
    chk("addr0", imem_addr, 64'h1000);
    tick();
    chk("exec_valid", {63'd0, instr_valid}, 64'd1);
    chk("exec_req", {63'd0, imem_req}, 64'd0);
    chk("exec_instr", {32'd0, instr}, 64'hABCD_1234);
    chk("exec_opcode", {53'd0, opcode}, {53'd0, 11'h55E});
    imem_data = 32'h1111_2222;
    tick();
    chk("seq_pc1", currentpc, 64'h1004);
    chk("fetch_valid", {63'd0, instr_valid}, 64'd0);
    chk("fetch_instr", {32'd0, instr}, 64'd0);
    tick();
    chk("exec2_instr", {32'd0, instr}, 64'h1111_2222);
    tick();
    chk("seq_pc2", currentpc, 64'h1008);

    do_reset(64'h2000);
    imem_ack = 1'b1;
    tick();
    branch = 1'b1; zero = 1'b1; extimm = -64'sd2;
    tick();
    chk("beq_taken", currentpc, 64'h1FF8);
    no_br();

    do_reset(64'h2000);
    imem_ack = 1'b1;
    tick();
    branch = 1'b1; zero = 1'b0; extimm = -64'sd2;
    tick();
    chk("beq_not_taken", currentpc, 64'h2004);
    no_br();

    do_reset(64'h100);
    imem_ack = 1'b1;
    tick();
    uncond_branch = 1'b1; branch = 1'bx; zero = 1'bx; extimm = 64'h10;
    tick();
    chk("uncond", currentpc, 64'h140);
    uncond_branch = 1'bx; branch = 1'bx; zero = 1'bx; extimm = 'x;
    tick();
    no_br();
    tick();
    chk("x_outside_exec", currentpc, 64'h144);

    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    tick();
    chk("pc_wrap", currentpc, 64'h0);

    do_reset(64'h3000);
    imem_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_to_fault", {63'd0, fault}, 64'd0);
    chk("pre_to_req", {63'd0, imem_req}, 64'd1);
    tick();
    chk("to_fault", {63'd0, fault}, 64'd1);
    chk("to_req", {63'd0, imem_req}, 64'd0);
    imem_ack = 1'b1;
    tick();
    tick();
    chk("late_ack_fault", {63'd0, fault}, 64'd1);
    chk("late_ack_valid", {63'd0, instr_valid}, 64'd0);
    chk("fault_pc", currentpc, 64'h3000);
    do_reset(64'h3000);
    chk("fault_cleared", {63'd0, fault}, 64'd0);
    #1;
    chk("refetch_req", {63'd0, imem_req}, 64'd1);
    chk("refetch_addr", imem_addr, 64'h3000);

    do_reset(64'h4000);
    imem_ack = 1'b0;
    tick();
    tick();
    tick();
    imem_ack = 1'b1;
    imem_data = 32'hCAFE_F00D;
    tick();
    chk("ack_on_to_fault", {63'd0, fault}, 64'd0);
    chk("ack_on_to_valid", {63'd0, instr_valid}, 64'd1);
    chk("ack_on_to_instr", {32'd0, instr}, 64'hCAFE_F00D);

    tick();
    reset = 1'b1;
    startpc = 64'h5000;
    imem_ack = 1'b1;
    #1;
    chk("rst_mid_req", {63'd0, imem_req}, 64'd0);
    tick();
    chk("rst_mid_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_mid_pc", currentpc, 64'h5000);
    reset = 1'b0;
    imem_ack = 1'b0;
    tick();
    chk("rst_mid_after", {63'd0, instr_valid}, 64'd0);
    chk("rst_mid_req2", {63'd0, imem_req}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255: maximum cycles in FETCH without imem_ack before a fault is raised; valid range 1..65535.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 startpc  input  64  PC loaded on reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  64  fetch address; always equals currentpc.
REQ-007 imem_ack  input  1  memory response valid; imem_data is sampled in the same cycle.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 branch  input  1  conditional-branch control from the decoder.
REQ-010 uncond_branch  input  1  unconditional-branch control from the decoder.
REQ-011 zero  input  1  ALU zero flag for the current instruction.
REQ-012 extimm  input  64  sign-extended branch offset, in instructions (words).
REQ-013 currentpc  output  64  PC of the instruction being fetched or executed.
REQ-014 instr  output  32  current instruction word.
REQ-015 opcode  output  11  instr[31:21], fed to the control decoder.
REQ-016 instr_valid  output  1  high for exactly the EXEC cycle.
REQ-017 fault  output  1  sticky fetch-timeout indicator.

Function
REQ-018 The FSM SHALL have three states: FETCH, EXEC and FAULT, encoded as a registered state variable.
REQ-019 In FETCH: imem_req=1, instr_valid=0; on imem_ack=1, capture imem_data into the instruction register and go to EXEC next cycle.
REQ-020 In FETCH without ack: increment the wait counter by 1; when the counter equals ACK_TIMEOUT-1 and imem_ack=0, go to FAULT.
REQ-021 An ack in the same cycle as the timeout condition SHALL win: go to EXEC, no fault.
REQ-022 The wait counter SHALL clear on every entry into FETCH and never wrap.
REQ-023 In EXEC: imem_req=0, instr_valid=1 for one cycle; at the end of the cycle, load currentpc with nextpc and return to FETCH.
REQ-024 nextpc SHALL be:
  - currentpc + (extimm<<2) if uncond_branch=1, regardless of branch;
  - else currentpc + (extimm<<2) if branch=1 and zero=1;
  - else currentpc + 4.
  All arithmetic is 64-bit modulo 2^64; wrap-around is silent.
REQ-025 branch, uncond_branch, zero and extimm SHALL be sampled only in EXEC; X values on these inputs outside EXEC SHALL NOT affect state.
REQ-026 instr SHALL equal the captured word while instr_valid=1 and 32'h00000000 otherwise; opcode therefore reads 11'b0, which decodes to the no-write default.
REQ-027 imem_ack SHALL be ignored in EXEC and FAULT.
REQ-028 In FAULT: imem_req=0, instr_valid=0, fault=1, currentpc frozen; only reset exits FAULT.
REQ-029 Minimum instruction period SHALL be 2 cycles (ack in the first FETCH cycle, then EXEC).

Reset
REQ-030 With reset=1 at a clock edge, set: state=FETCH, currentpc=startpc, wait counter=0, instruction register=0, fault=0.
REQ-031 While reset=1, imem_req=0 and instr_valid=0; imem_req SHALL rise in the first cycle after reset deasserts.
REQ-032 Reset asserted in any state, including mid-FETCH with a pending ack, SHALL take priority; the ack is discarded.

Verification
REQ-033 reset with startpc=0x1000, ack every FETCH cycle, no branches -> currentpc 0x1000, 0x1004, 0x1008; instr_valid pulses every 2nd cycle.
REQ-034 EXEC at pc=0x2000 with branch=1, zero=1, extimm=-2 -> next currentpc=0x1FF8; same with zero=0 -> 0x2004.
REQ-035 uncond_branch=1, branch=X, extimm=0x10 at pc=0x100 -> next currentpc=0x140.
REQ-036 ACK_TIMEOUT=4, no ack -> fault=1 after 4 FETCH cycles, imem_req=0 thereafter; a late ack is ignored; reset clears fault and refetches startpc.
REQ-037 ack arriving on the timeout cycle -> EXEC, fault stays 0.
REQ-038 pc=0xFFFFFFFFFFFFFFFC, no branch -> next currentpc=0x0; reset asserted mid-FETCH with ack -> instr_valid stays 0, currentpc=startpc.
